// File: rtl/fetch_unit_pkg.sv
// Shared types and sizing helpers for the instruction-fetch unit.
package fetch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } fetch_state_e;

  // Width of the read-latency counter: $clog2(RAM_LATENCY+1), never below 1.
  function automatic int cnt_width(input int ram_latency);
    int w;
    w = $clog2(ram_latency + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fetch_unit_ena_reg.sv
// Enable register with async reset and synchronous clear (clear wins over enable).
module ena_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             ena,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: clear, load or hold.
  always_comb begin
    q_d = q_q;
    if (sclr) begin
      q_d = '0;
    end else if (ena) begin
      q_d = d;
    end
  end

  // Storage flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch unit: MAR, IR and PC registers behind an IDLE/READ FSM
// that holds a fixed-latency RAM read and pulses instr_valid on capture.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3,
  parameter int RAM_LATENCY  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sclr,
  input  logic                           fetch,
  input  logic                           jump_en,
  input  logic [ADDR_WIDTH-1:0]          busC,
  input  logic [DATA_WIDTH-1:0]          ram_rdata,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic                           ram_rd,
  output logic [ADDR_WIDTH-1:0]          pc,
  output logic [OPCODE_WIDTH-1:0]        opcode,
  output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] operand,
  output logic                           busy,
  output logic                           instr_valid
);

  localparam int CNT_W = cnt_width(RAM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);

  fetch_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            instr_valid_q, instr_valid_d;

  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] ir;

  logic                  idle;
  logic                  start_read;
  logic                  done;
  logic                  mar_ena;
  logic                  ir_ena;
  logic                  pc_ena;
  logic [ADDR_WIDTH-1:0] mar_d;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Datapath control decoded from the current state and requests.
  always_comb begin
    idle       = (state_q == ST_IDLE);
    start_read = idle && fetch;
    done       = (state_q == ST_READ) && (cnt_q == CNT_LAST);
    mar_ena    = start_read;
    mar_d      = jump_en ? busC : pc;
    ir_ena     = done;
    pc_ena     = done || (idle && !fetch && jump_en);
    pc_d       = done ? (mar + ADDR_WIDTH'(1)) : busC;
  end

  // FSM next state, latency counter and registered status outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    instr_valid_d = 1'b0;
    if (sclr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fetch) begin
            state_d = ST_READ;
            cnt_d   = '0;
          end
        end
        ST_READ: begin
          if (done) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            instr_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == ST_READ);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  ena_reg #(.WIDTH(ADDR_WIDTH)) u_mar (
    .clk  (clk),
    .rst  (rst),
    .sclr (sclr),
    .ena  (mar_ena),
    .d    (mar_d),
    .q    (mar)
  );

  ena_reg #(.WIDTH(DATA_WIDTH)) u_ir (
    .clk  (clk),
    .rst  (rst),
    .sclr (sclr),
    .ena  (ir_ena),
    .d    (ram_rdata),
    .q    (ir)
  );

  ena_reg #(.WIDTH(ADDR_WIDTH)) u_pc (
    .clk  (clk),
    .rst  (rst),
    .sclr (sclr),
    .ena  (pc_ena),
    .d    (pc_d),
    .q    (pc)
  );

  assign ram_addr    = mar;
  assign ram_rd      = busy_q;
  assign busy        = busy_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = ir[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign operand     = ir[DATA_WIDTH-OPCODE_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       sclr = 1'b0, fetch = 1'b0, jump_en = 1'b0;
  logic [7:0] busC = 8'h00, ram_rdata = 8'h00;
  logic [7:0] ram_addr, pc;
  logic       ram_rd, busy, instr_valid;
  logic [2:0] opcode;
  logic [4:0] operand;

  logic       fetch1 = 1'b0;
  logic [7:0] ram_addr1, pc1;
  logic       ram_rd1, busy1, valid1;
  logic [2:0] opcode1;
  logic [4:0] operand1;

  logic       fetch3 = 1'b0;
  logic [7:0] ram_addr3, pc3;
  logic       ram_rd3, busy3, valid3;
  logic [2:0] opcode3;
  logic [4:0] operand3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .OPCODE_WIDTH(3), .RAM_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .fetch(fetch), .jump_en(jump_en), .busC(busC),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_rd(ram_rd), .pc(pc),
    .opcode(opcode), .operand(operand), .busy(busy), .instr_valid(instr_valid)
  );

  fetch_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .OPCODE_WIDTH(3), .RAM_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .sclr(1'b0), .fetch(fetch1), .jump_en(1'b0), .busC(8'h00),
    .ram_rdata(8'h5A), .ram_addr(ram_addr1), .ram_rd(ram_rd1), .pc(pc1),
    .opcode(opcode1), .operand(operand1), .busy(busy1), .instr_valid(valid1)
  );

  fetch_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .OPCODE_WIDTH(3), .RAM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .sclr(1'b0), .fetch(fetch3), .jump_en(1'b0), .busC(8'h00),
    .ram_rdata(8'hA5), .ram_addr(ram_addr3), .ram_rd(ram_rd3), .pc(pc3),
    .opcode(opcode3), .operand(operand3), .busy(busy3), .instr_valid(valid3)
  );

  // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests++;
    if ({ram_addr, ram_rd, pc, opcode, operand, busy, instr_valid} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outputs: got addr=%h rd=%b pc=%h op=%b opnd=%b busy=%b valid=%b, want all 0",
               ram_addr, ram_rd, pc, opcode, operand, busy, instr_valid);
    end
    tests++;
    if ({ram_rd1, pc1, valid1, ram_rd3, pc3, valid3} !== 20'd0) begin
      fails++;
      $display("FAIL reset_aux: got rd1=%b pc1=%h v1=%b rd3=%b pc3=%h v3=%b, want 0",
               ram_rd1, pc1, valid1, ram_rd3, pc3, valid3);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_seq_fetch();
    fetch = 1'b1; ram_rdata = 8'hF0;
    tick();
    fetch = 1'b0;
    tests++;
    if (ram_addr !== 8'h00 || ram_rd !== 1'b1 || busy !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL seq_cycle1: got addr=%h rd=%b busy=%b valid=%b, want 00 1 1 0",
               ram_addr, ram_rd, busy, instr_valid);
    end
    tick();
    tests++;
    if (ram_addr !== 8'h00 || ram_rd !== 1'b1 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL seq_cycle2: got addr=%h rd=%b valid=%b, want 00 1 0", ram_addr, ram_rd, instr_valid);
    end
    tick();
    tests++;
    if (instr_valid !== 1'b1 || ram_rd !== 1'b0 || opcode !== 3'b111 || operand !== 5'b10000 || pc !== 8'h01) begin
      fails++;
      $display("FAIL seq_capture: got valid=%b rd=%b op=%b opnd=%b pc=%h, want 1 0 111 10000 01",
               instr_valid, ram_rd, opcode, operand, pc);
    end
    tick();
    tests++;
    if (instr_valid !== 1'b0 || opcode !== 3'b111 || operand !== 5'b10000) begin
      fails++;
      $display("FAIL seq_pulse_end: got valid=%b op=%b opnd=%b, want 0 111 10000", instr_valid, opcode, operand);
    end
  endtask

  task automatic test_jump_fetch();
    fetch = 1'b1; jump_en = 1'b1; busC = 8'h0C; ram_rdata = 8'h3C;
    tick();
    fetch = 1'b0; jump_en = 1'b0; busC = 8'h99;
    tests++;
    if (ram_addr !== 8'h0C || ram_rd !== 1'b1) begin
      fails++;
      $display("FAIL jf_addr: got addr=%h rd=%b, want 0c 1", ram_addr, ram_rd);
    end
    tick();
    tick();
    tests++;
    if (instr_valid !== 1'b1 || {opcode, operand} !== 8'h3C || pc !== 8'h0D) begin
      fails++;
      $display("FAIL jf_capture: got valid=%b ir=%h pc=%h, want 1 3c 0d", instr_valid, {opcode, operand}, pc);
    end
    tick();
  endtask

  task automatic test_jump_only();
    jump_en = 1'b1; busC = 8'h70;
    tick();
    jump_en = 1'b0; busC = 8'h00;
    tests++;
    if (pc !== 8'h70 || ram_rd !== 1'b0 || instr_valid !== 1'b0 || ram_addr !== 8'h0C) begin
      fails++;
      $display("FAIL jump_only: got pc=%h rd=%b valid=%b addr=%h, want 70 0 0 0c", pc, ram_rd, instr_valid, ram_addr);
    end
    fetch = 1'b1; ram_rdata = 8'h21;
    tick();
    fetch = 1'b0;
    tests++;
    if (ram_addr !== 8'h70 || ram_rd !== 1'b1) begin
      fails++;
      $display("FAIL jump_then_fetch_addr: got addr=%h rd=%b, want 70 1", ram_addr, ram_rd);
    end
    tick();
    tick();
    tests++;
    if (instr_valid !== 1'b1 || pc !== 8'h71 || {opcode, operand} !== 8'h21) begin
      fails++;
      $display("FAIL jump_then_fetch_done: got valid=%b pc=%h ir=%h, want 1 71 21", instr_valid, pc, {opcode, operand});
    end
    tick();
  endtask

  task automatic test_wrap_ignore();
    int pulses;
    jump_en = 1'b1; busC = 8'hFF;
    tick();
    jump_en = 1'b0;
    fetch = 1'b1; ram_rdata = 8'hAA;
    tick();
    fetch = 1'b1; jump_en = 1'b1; busC = 8'h33;
    tick();
    fetch = 1'b0; jump_en = 1'b0; busC = 8'h00;
    tests++;
    if (ram_addr !== 8'hFF || ram_rd !== 1'b1) begin
      fails++;
      $display("FAIL wrap_busy_addr: got addr=%h rd=%b, want ff 1", ram_addr, ram_rd);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (instr_valid === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL wrap_pulses: got %0d valid pulses, want 1", pulses);
    end
    tests++;
    if (pc !== 8'h00 || ram_rd !== 1'b0 || {opcode, operand} !== 8'hAA) begin
      fails++;
      $display("FAIL wrap_pc: got pc=%h rd=%b ir=%h, want 00 0 aa", pc, ram_rd, {opcode, operand});
    end
  endtask

  task automatic test_sclr_abort();
    int pulses;
    jump_en = 1'b1; busC = 8'h40;
    tick();
    jump_en = 1'b0;
    fetch = 1'b1; ram_rdata = 8'h77;
    tick();
    fetch = 1'b0;
    sclr = 1'b1; fetch = 1'b1;
    tick();
    sclr = 1'b0; fetch = 1'b0;
    tests++;
    if (ram_rd !== 1'b0 || busy !== 1'b0 || ram_addr !== 8'h00 || pc !== 8'h00 ||
        {opcode, operand} !== 8'h00 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL sclr_abort: got rd=%b busy=%b addr=%h pc=%h ir=%h valid=%b, want all 0",
               ram_rd, busy, ram_addr, pc, {opcode, operand}, instr_valid);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (instr_valid === 1'b1 || ram_rd === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || pc !== 8'h00) begin
      fails++;
      $display("FAIL sclr_quiet: got %0d active cycles pc=%h, want 0 00", pulses, pc);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n3, last1, last3, bad;
    n1 = 0; n3 = 0; last1 = -1; last3 = -1; bad = 0;
    fetch1 = 1'b1; fetch3 = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (valid1 === 1'b1) begin
        n1++;
        if (pc1 !== 8'(n1) || opcode1 !== 3'b010 || (last1 >= 0 && c - last1 != 2) || (last1 < 0 && c != 2)) begin
          bad++;
          $display("FAIL b2b_lat1: cycle %0d got pc=%h op=%b gap=%0d, want pc=%h op=010 gap=2",
                   c, pc1, opcode1, c - last1, 8'(n1));
        end
        last1 = c;
      end
      if (valid3 === 1'b1) begin
        n3++;
        if (pc3 !== 8'(n3) || opcode3 !== 3'b101 || (last3 >= 0 && c - last3 != 4) || (last3 < 0 && c != 4)) begin
          bad++;
          $display("FAIL b2b_lat3: cycle %0d got pc=%h op=%b gap=%0d, want pc=%h op=101 gap=4",
                   c, pc3, opcode3, c - last3, 8'(n3));
        end
        last3 = c;
      end
    end
    fetch1 = 1'b0; fetch3 = 1'b0;
    tests++;
    if (bad != 0) fails++;
    tests++;
    if (n1 != 8) begin
      fails++;
      $display("FAIL b2b_count_lat1: got %0d pulses, want 8", n1);
    end
    tests++;
    if (n3 != 4) begin
      fails++;
      $display("FAIL b2b_count_lat3: got %0d pulses, want 4", n3);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_seq_fetch();
    test_jump_fetch();
    test_jump_only();
    test_wrap_ignore();
    test_sclr_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch unit for the memory system. It combines the memory address register, the instruction register and a program counter behind a fetch state machine that drives a fixed-latency RAM read. On each `fetch` request it loads the MAR, holds the RAM read for `RAM_LATENCY` cycles, captures the returned word in the IR, advances the PC and pulses `instr_valid`. Jumps load the PC or MAR from busC, and instructions are decoded into opcode and operand fields.

## Interface
- `DATA_WIDTH`, 8, RAM word and IR width.
- `ADDR_WIDTH`, 8, MAR/PC width and RAM address width.
- `OPCODE_WIDTH`, 3, number of IR MSBs presented as the opcode; must be less than `DATA_WIDTH`.
- `RAM_LATENCY`, 2, number of cycles `ram_rd` is held before data is captured; must be at least 1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sclr`  in  1  synchronous clear, same effect as `rst`, highest priority at the edge.
- `fetch`  in  1  fetch request; sampled only in IDLE.
- `jump_en`  in  1  use `busC` as target address; sampled only in IDLE.
- `busC`  in  ADDR_WIDTH  jump target address.
- `ram_rdata`  in  DATA_WIDTH  RAM read data; valid on the final READ cycle.
- `ram_addr`  out  ADDR_WIDTH  MAR contents.
- `ram_rd`  out  1  RAM read strobe; high throughout READ.
- `pc`  out  ADDR_WIDTH  program counter.
- `opcode`  out  OPCODE_WIDTH  `ir[DATA_WIDTH-1 -: OPCODE_WIDTH]`.
- `operand`  out  DATA_WIDTH-OPCODE_WIDTH  `ir[DATA_WIDTH-OPCODE_WIDTH-1:0]`.
- `busy`  out  1  high while in READ.
- `instr_valid`  out  1  one-cycle pulse after the IR is loaded.

## Operation
- States: IDLE and READ.
- IDLE, `fetch`=1:
  - `mar` ← `jump_en` ? `busC` : `pc`.
  - Latency counter ← 0; go to READ.
- IDLE, `fetch`=0, `jump_en`=1: `pc` ← `busC`; no RAM access.
- IDLE, neither asserted: all registers hold.
- READ:
  - `ram_rd`=1 and `busy`=1; counter increments each cycle.
  - On the edge ending the RAM_LATENCY-th READ cycle: `ir` ← `ram_rdata`, `pc` ← `mar`+1, state ← IDLE, `instr_valid` ← 1.
  - `fetch` and `jump_en` are ignored while in READ (no queuing).
- `instr_valid` is registered. It is high for exactly one cycle, the first IDLE cycle after READ.
- PC increment is modulo 2^ADDR_WIDTH: all-ones wraps to 0.
- A fetch with jump sets `pc` to `busC`+1 at completion.
- Reset, and `sclr` at an edge, clear the following to 0: `mar`, `ir`, `pc`, counter, `instr_valid`. State returns to IDLE.
  - This applies mid-READ too: the read is aborted, `ram_rd` drops and no capture or `instr_valid` occurs.
  - `sclr` overrides a simultaneous `fetch` or `jump_en`.
- Reset value of every output is 0: `ram_addr`, `ram_rd`, `pc`, `opcode`, `operand`, `busy`, `instr_valid`.

## Timing
- `fetch` sampled at edge 0 → READ occupies cycles 1..RAM_LATENCY, with `ram_addr` and `ram_rd` valid from cycle 1.
- IR and PC update at the end of cycle RAM_LATENCY; `instr_valid` is high in cycle RAM_LATENCY+1.
- Fetch-to-valid latency is RAM_LATENCY+1 cycles.
- Back-to-back: `fetch` held high during the `instr_valid` cycle starts the next READ at the following edge.
  - Throughput is one instruction per RAM_LATENCY+1 cycles.
- `opcode` and `operand` are combinational slices of `ir`. They are stable from the `instr_valid` cycle until the next capture.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_READ`);
  - the counter width constant `$clog2(RAM_LATENCY+1)`.
- Sub-module `ena_reg`: a parametrised-width register with `clk`/`rst`/`sclr`/`ena`/`d`/`q`. It is instantiated for `mar`, `ir` and `pc`.
- FSM and counter live in `fetch_unit` top-level logic.

## Test plan
1. Reset, then sequential fetch:
   - Stimulus: `rst`=1 for 1 cycle, then `fetch` with `pc`=0 and `ram_rdata`=8'hF0.
   - Required: all outputs 0 after reset; `ram_addr`=0 and `ram_rd`=1 for 2 cycles; `instr_valid` in cycle 3; `opcode`=3'b111, `operand`=5'b10000, `pc`=1.
2. Jump-fetch:
   - Stimulus: `fetch`=1, `jump_en`=1, `busC`=8'h0C, `ram_rdata`=8'h3C.
   - Required: `ram_addr`=8'h0C, `ir`=8'h3C, `pc`=8'h0D.
3. Jump without fetch:
   - Stimulus: `jump_en`=1, `busC`=8'h70.
   - Required: `pc`=8'h70 next cycle, `ram_rd` stays 0; a following `fetch` reads from 8'h70.
4. Wrap, and fetch ignored while busy:
   - Stimulus: fetch from `pc`=8'hFF, with `fetch` pulsed again during READ.
   - Required: `pc`=0 after completion; only one `instr_valid` pulse.
5. `sclr` abort:
   - Stimulus: `sclr`=1 in the first READ cycle.
   - Required: next cycle state is IDLE, `ram_rd`=0, `mar`/`ir`/`pc`=0, no `instr_valid`.
6. Back-to-back with RAM_LATENCY=1 and 3:
   - Stimulus: `fetch` held high continuously.
   - Required: `instr_valid` every 2 and every 4 cycles respectively; PC increments by 1 per pulse.
